// File: rtl/watches_pkg.sv
// -----------------------------------------------------------------------------
// watches_pkg
// Shared types and helpers for the watch time-setting logic.
//   set_state_e : time-setting FSM states (RUN = normal timekeeping,
//                 SET = user is adjusting the time)
//   cnt_w()     : counter width able to hold values 0..max_val
// -----------------------------------------------------------------------------
package watches_pkg;

    typedef enum logic {
        RUN = 1'b0,
        SET = 1'b1
    } set_state_e;

    function automatic int cnt_w(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/time_set_ctrl_btn_cond.sv
// -----------------------------------------------------------------------------
// btn_cond
// Conditions one raw push button: 2-flop synchronizer, debounce, one-cycle
// press event and (optionally) hold-to-repeat events.
//   clk_i  : clock
//   rst_i  : asynchronous active-high reset
//   btn_i  : raw asynchronous button, active-high
//   lvl_o  : debounced button level
//   evt_o  : one-cycle event on press, then on each auto-repeat tick
// Parameters: DEBOUNCE_CYC, HOLD_CYC, REPEAT_CYC, REPEAT_EN
// -----------------------------------------------------------------------------
module btn_cond
    import watches_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 500000,
    parameter int HOLD_CYC     = 25000000,
    parameter int REPEAT_CYC   = 5000000,
    parameter bit REPEAT_EN    = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic lvl_o,
    output logic evt_o
);

    localparam int                DB_W    = cnt_w(DEBOUNCE_CYC);
    localparam logic [DB_W-1:0]   DB_LAST = DB_W'((DEBOUNCE_CYC > 0) ? DEBOUNCE_CYC - 1 : 0);
    localparam int                RP_MAX  = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
    localparam int                RP_W    = cnt_w(RP_MAX);
    localparam logic [RP_W-1:0]   RP_SAT  = RP_W'(RP_MAX);
    localparam logic [RP_W-1:0]   HOLD_T  = RP_W'(HOLD_CYC);
    localparam logic [RP_W-1:0]   REP_T   = RP_W'(REPEAT_CYC);

    logic            sync_p0, sync_p1;
    logic            vld_p0, vld_p1;
    logic            rdy;
    logic [DB_W-1:0] db_cnt;
    logic            deb, deb_q;
    logic            press_p;
    logic            armed, rep_phase;
    logic [RP_W-1:0] rp_cnt;
    logic            rep_hit;

    // ---- stage p0/p1: synchronizer ----
    // vld_pN marks synchronizer contents that came from the pin rather than
    // from reset. rdy latches once the button has been seen released, so a
    // button held through reset release never yields a press event.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            vld_p0  <= 1'b0;
            vld_p1  <= 1'b0;
            rdy     <= 1'b0;
        end else begin
            sync_p0 <= btn_i;
            sync_p1 <= sync_p0;
            vld_p0  <= 1'b1;
            vld_p1  <= vld_p0;
            rdy     <= rdy | (vld_p1 & ~sync_p1);
        end
    end

    // ---- debounce and press event ----
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            db_cnt  <= '0;
            deb     <= 1'b0;
            deb_q   <= 1'b0;
            press_p <= 1'b0;
        end else begin
            if (sync_p1 == deb) begin
                db_cnt <= '0;
            end else if (db_cnt >= DB_LAST) begin
                deb    <= sync_p1;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
            deb_q   <= deb;
            press_p <= deb & ~deb_q & rdy;
        end
    end

    // ---- auto-repeat ----
    // rp_cnt holds the number of cycles since the last event of this hold;
    // the first tick waits HOLD_CYC, later ticks REPEAT_CYC. Any cycle with
    // the debounced level low disarms immediately.
    assign rep_hit = REPEAT_EN && armed && deb &&
                     (rp_cnt == (rep_phase ? REP_T : HOLD_T));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            armed     <= 1'b0;
            rep_phase <= 1'b0;
            rp_cnt    <= '0;
        end else if (!deb) begin
            armed     <= 1'b0;
            rep_phase <= 1'b0;
            rp_cnt    <= '0;
        end else if (press_p) begin
            armed     <= REPEAT_EN;
            rep_phase <= 1'b0;
            rp_cnt    <= RP_W'(1);
        end else if (rep_hit) begin
            rep_phase <= 1'b1;
            rp_cnt    <= RP_W'(1);
        end else if (armed && (rp_cnt != RP_SAT)) begin
            rp_cnt    <= rp_cnt + RP_W'(1);
        end
    end

    assign lvl_o = deb;
    assign evt_o = press_p | rep_hit;

endmodule

// File: rtl/time_set_ctrl.sv
// -----------------------------------------------------------------------------
// time_set_ctrl
// Watch time-setting controller. The set button toggles between RUN and SET;
// in SET the minute/hour buttons produce increment pulses (with hold-to-
// repeat), and SET falls back to RUN after TIMEOUT_CYC idle cycles.
//   clk_i           : clock
//   rst_i           : asynchronous active-high reset
//   btn_set_i       : raw set button
//   btn_min_i       : raw minute button
//   btn_hour_i      : raw hour button
//   user_time_val_o : high while in SET mode
//   user_min_up_o   : one-cycle minute increment pulse
//   user_hour_up_o  : one-cycle hour increment pulse
// -----------------------------------------------------------------------------
module time_set_ctrl
    import watches_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 500000,
    parameter int HOLD_CYC     = 25000000,
    parameter int REPEAT_CYC   = 5000000,
    parameter int TIMEOUT_CYC  = 500000000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_set_i,
    input  logic btn_min_i,
    input  logic btn_hour_i,
    output logic user_time_val_o,
    output logic user_min_up_o,
    output logic user_hour_up_o
);

    localparam int               TMO_W    = cnt_w(TIMEOUT_CYC);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
    localparam logic [TMO_W-1:0] TMO_SAT  = TMO_W'(TIMEOUT_CYC);

    logic             set_evt, min_evt, hour_evt;
    logic             set_lvl_unused;   // only the set button's events matter
    logic             min_lvl, hour_lvl;
    set_state_e       state, state_nxt;
    logic             acc_min, acc_hour;
    logic             timeout;
    logic             min_blk, hour_blk;
    logic [TMO_W-1:0] tmo_cnt;

    btn_cond #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC),
        .HOLD_CYC     (HOLD_CYC),
        .REPEAT_CYC   (REPEAT_CYC),
        .REPEAT_EN    (1'b0)
    ) u_set (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .btn_i (btn_set_i),
        .lvl_o (set_lvl_unused),
        .evt_o (set_evt)
    );

    btn_cond #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC),
        .HOLD_CYC     (HOLD_CYC),
        .REPEAT_CYC   (REPEAT_CYC),
        .REPEAT_EN    (1'b1)
    ) u_min (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .btn_i (btn_min_i),
        .lvl_o (min_lvl),
        .evt_o (min_evt)
    );

    btn_cond #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC),
        .HOLD_CYC     (HOLD_CYC),
        .REPEAT_CYC   (REPEAT_CYC),
        .REPEAT_EN    (1'b1)
    ) u_hour (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .btn_i (btn_hour_i),
        .lvl_o (hour_lvl),
        .evt_o (hour_evt)
    );

    assign timeout = (TIMEOUT_CYC != 0) && (state == SET) && (tmo_cnt == TMO_LAST);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // A set event always wins: min/hour events arriving with it, or in the
    // timeout cycle, are dropped. Buttons still held from before SET entry
    // stay blocked until released.
    always_comb begin
        state_nxt = state;
        acc_min   = 1'b0;
        acc_hour  = 1'b0;
        case (state)
            RUN: begin
                if (set_evt) begin
                    state_nxt = SET;
                end
            end
            SET: begin
                if (set_evt || timeout) begin
                    state_nxt = RUN;
                end else begin
                    acc_min  = min_evt & ~min_blk;
                    acc_hour = hour_evt & ~hour_blk;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    // ---- registered outputs, hold-over blocking, idle timeout ----
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            user_time_val_o <= 1'b0;
            user_min_up_o   <= 1'b0;
            user_hour_up_o  <= 1'b0;
            min_blk         <= 1'b0;
            hour_blk        <= 1'b0;
            tmo_cnt         <= '0;
        end else begin
            user_time_val_o <= (state_nxt == SET);
            user_min_up_o   <= acc_min;
            user_hour_up_o  <= acc_hour;

            if ((state == RUN) && (state_nxt == SET)) begin
                min_blk  <= min_lvl;
                hour_blk <= hour_lvl;
            end else begin
                if (!min_lvl)  min_blk  <= 1'b0;
                if (!hour_lvl) hour_blk <= 1'b0;
            end

            if ((state == RUN) || acc_min || acc_hour) begin
                tmo_cnt <= '0;
            end else if (tmo_cnt != TMO_SAT) begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
        end
    end

endmodule
